binary_search_engine: RTL and testbench

Parametrised, self-sequencing binary search over an ascending-sorted synchronous memory. It replaces the hand-driven compare datapath with an engine that owns its own FSM, address generation, memory-latency wait and result reporting behind a start/done handshake. It sits between a control client and a sorted lookup RAM, and reports whether a key exists and at which address.

---
 rtl/binary_search_engine_pkg.sv | 31 +++
 rtl/binary_search_engine.sv | 195 +++++++++++++++++++
 tb/tb_binary_search_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/binary_search_engine_pkg.sv
// ----------------------------------------------------------------------------
// bsearch_pkg
//   Shared definitions for binary_search_engine:
//     - bse_state_t  : FSM state encoding (IDLE, READ, WAIT, CMP, DONE)
//     - worst_probes : number of probes needed in the worst case for a table
//                      of 'depth' entries, i.e. ceil(log2(depth+1)), which is
//                      the bit length of 'depth'.
// ----------------------------------------------------------------------------
package bsearch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } bse_state_t;

    function automatic int worst_probes(input int depth);
        int probes;
        int span;
        probes = 0;
        span   = depth;
        while (span > 0) begin
            span   = span >> 1;
            probes = probes + 1;
        end
        return probes;
    endfunction

endpackage

// File: rtl/binary_search_engine.sv
// ----------------------------------------------------------------------------
// binary_search_engine
//   Self-sequencing binary search over an ascending-sorted synchronous memory.
//   A client pulses 'start' with a 'key'; the engine probes the memory over a
//   half-open interval [lo, hi), waits out the read latency, compares, narrows
//   the interval, and finally pulses 'done' with 'found'/'index'.
//
//   Configuration macro: BSEARCH_LOWER_BOUND_EN
//     defined   : on a miss, index = final lo (first address whose word
//                 exceeds key; may equal DEPTH)
//     undefined : on a miss, index = 0
//
//   Parameters
//     DATA_W  key / memory word width (unsigned)
//     ADDR_W  memory address width
//     DEPTH   number of valid entries, 1 <= DEPTH <= 2^ADDR_W
//     MEM_LAT read latency from mem_rd to valid mem_data, >= 1
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset
//     start     in   search request, sampled only while idle
//     key       in   search key, captured when start is accepted
//     mem_addr  out  probe address
//     mem_rd    out  one-cycle read strobe per probe
//     mem_data  in   memory word, valid MEM_LAT cycles after mem_rd
//     busy      out  high from the cycle after start until DONE inclusive
//     done      out  one-cycle result-valid pulse
//     found     out  key present
//     index     out  match address or insertion point (ADDR_W+1 bits)
// ----------------------------------------------------------------------------
module binary_search_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W:0]   index
);

    localparam int IW        = ADDR_W + 1;
    localparam int CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // Last value of the wait counter before moving on to CMP; only
    // meaningful when MEM_LAT > 1 (WAIT is unreachable otherwise).
    localparam int WAIT_LAST = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

    bse_state_t        r_state;
    logic [IW-1:0]     r_lo;
    logic [IW-1:0]     r_hi;
    logic [DATA_W-1:0] r_key;
    logic              r_found;
    logic [IW-1:0]     r_index;
    logic [CNT_W-1:0]  r_wait;

    bse_state_t        w_state_nxt;
    logic [IW-1:0]     w_lo_nxt;
    logic [IW-1:0]     w_hi_nxt;
    logic [DATA_W-1:0] w_key_nxt;
    logic              w_found_nxt;
    logic [IW-1:0]     w_index_nxt;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic [IW-1:0]     w_mid;

    // lo + (hi-lo)/2 avoids the overflow that (lo+hi)/2 would have at the
    // top of the address range; with lo < hi, mid is always < hi <= DEPTH.
    assign w_mid = r_lo + ((r_hi - r_lo) >> 1);

    assign found = r_found;
    assign index = r_index;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
            r_key   <= '0;
            r_found <= 1'b0;
            r_index <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_key   <= w_key_nxt;
            r_found <= w_found_nxt;
            r_index <= w_index_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, datapath update and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_key_nxt   = r_key;
        w_found_nxt = r_found;
        w_index_nxt = r_index;
        w_wait_nxt  = r_wait;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_key_nxt   = key;
                    w_lo_nxt    = '0;
                    w_hi_nxt    = IW'(DEPTH);
                    w_found_nxt = 1'b0;
                    w_state_nxt = READ;
                end
            end

            READ: begin
                busy       = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = w_mid[ADDR_W-1:0];
                w_wait_nxt = '0;
                w_state_nxt = (MEM_LAT == 1) ? CMP : WAIT;
            end

            WAIT: begin
                busy = 1'b1;
                if (r_wait == CNT_W'(WAIT_LAST)) begin
                    w_state_nxt = CMP;
                end else begin
                    w_wait_nxt = r_wait + CNT_W'(1);
                end
            end

            CMP: begin
                busy = 1'b1;
                // lo/hi are unchanged since READ, so w_mid is still the
                // address whose word is now on mem_data.
                if (r_key == mem_data) begin
                    w_found_nxt = 1'b1;
                    w_index_nxt = w_mid;
                    w_state_nxt = DONE;
                end else begin
                    if (r_key > mem_data) begin
                        w_lo_nxt = w_mid + IW'(1);
                    end else begin
                        w_hi_nxt = w_mid;
                    end

                    if (w_lo_nxt == w_hi_nxt) begin
                        w_found_nxt = 1'b0;
`ifdef BSEARCH_LOWER_BOUND_EN
                        w_index_nxt = w_lo_nxt;
`else
                        w_index_nxt = '0;
`endif
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end

            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_binary_search_engine.sv
// ----------------------------------------------------------------------------
// tb_binary_search_engine
//   Directed bench for binary_search_engine. Two instances share clk/rst:
//   unit 0 with MEM_LAT=1 and unit 1 with MEM_LAT=3, each backed by a model
//   memory holding mem[i] = 2*i behind a MEM_LAT-deep read pipeline.
// ----------------------------------------------------------------------------
module tb_binary_search_engine;
    import bsearch_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

`ifdef BSEARCH_LOWER_BOUND_EN
    localparam int EXP_MISS_33  = 17;
    localparam int EXP_MISS_255 = 32;
`else
    localparam int EXP_MISS_33  = 0;
    localparam int EXP_MISS_255 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]              start = '0;
    logic [1:0][DATA_W-1:0]  key   = '0;
    logic [1:0][ADDR_W-1:0]  mem_addr;
    logic [1:0]              mem_rd;
    logic [1:0][DATA_W-1:0]  mem_data;
    logic [1:0]              busy;
    logic [1:0]              done;
    logic [1:0]              found;
    logic [1:0][ADDR_W:0]    index;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start[0]), .key(key[0]),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_data(mem_data[0]),
        .busy(busy[0]), .done(done[0]), .found(found[0]), .index(index[0])
    );

    binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start[1]), .key(key[1]),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_data(mem_data[1]),
        .busy(busy[1]), .done(done[1]), .found(found[1]), .index(index[1])
    );

    // Model memory: word i holds 2*i. Non-read cycles push a filler value so
    // a comparison at the wrong cycle sees garbage.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {2'b00, a, 1'b0};
    endfunction

    logic [DATA_W-1:0] pipe1;
    logic [DATA_W-1:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1    <= mem_rd[0] ? mem_word(mem_addr[0]) : 8'hA5;
        pipe3[0] <= mem_rd[1] ? mem_word(mem_addr[1]) : 8'hA5;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign mem_data[0] = pipe1;
    assign mem_data[1] = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch one search on unit 'sel' and check its result and timing.
    // Cycle n=0 is the cycle start is high; done is expected at n=exp_n.
    task automatic run_search(input int sel, input logic [DATA_W-1:0] k,
                              input int exp_found, input int exp_idx,
                              input int exp_n, input string tag);
        int n;
        int max_addr;
        int budget;
        bit seen;
        budget   = 4 * worst_probes(DEPTH) * 4 + 8;
        max_addr = 0;
        seen     = 1'b0;
        @(negedge clk);
        start[sel] = 1'b1;
        key[sel]   = k;
        @(negedge clk);
        start[sel] = 1'b0;
        n = 1;
        check({tag, "_rd_at_t1"}, 32'(mem_rd[sel]), 1);
        check({tag, "_busy_at_t1"}, 32'(busy[sel]), 1);
        check({tag, "_found_cleared"}, 32'(found[sel]), 0);
        for (int c = 0; c < budget; c++) begin
            if (mem_rd[sel] && int'(mem_addr[sel]) > max_addr) max_addr = int'(mem_addr[sel]);
            if (done[sel]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_done_cycle"}, 32'(n), 32'(exp_n));
            check({tag, "_found"}, 32'(found[sel]), 32'(exp_found));
            check({tag, "_index"}, 32'(index[sel]), 32'(exp_idx));
            check({tag, "_addr_in_range"}, 32'(max_addr < DEPTH), 1);
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done[sel]), 0);
            check({tag, "_idle_after"}, 32'(busy[sel]), 0);
            check({tag, "_found_held"}, 32'(found[sel]), 32'(exp_found));
        end
    endtask

    initial begin
        int done_cnt;

        repeat (3) @(negedge clk);
        // Reset values while rst is still asserted, then release.
        check("rst_busy",  32'(busy[0]), 0);
        check("rst_done",  32'(done[0]), 0);
        check("rst_found", 32'(found[0]), 0);
        check("rst_index", 32'(index[0]), 0);
        check("rst_rd",    32'(mem_rd[0]), 0);
        check("rst_addr",  32'(mem_addr[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        run_search(0, 8'd32,  1, 16,           3,  "k32");
        run_search(0, 8'd0,   1, 0,            13, "k0");
        run_search(0, 8'd33,  0, EXP_MISS_33,  11, "k33");
        run_search(0, 8'd255, 0, EXP_MISS_255, 11, "k255");
        run_search(0, 8'd62,  1, 31,           11, "k62");
        run_search(1, 8'd32,  1, 16,           5,  "lat3_k32");

        // Reset asserted during READ aborts the search with no done.
        @(negedge clk);
        start[0] = 1'b1;
        key[0]   = 8'd0;
        @(negedge clk);
        start[0] = 1'b0;
        check("abort_in_read", 32'(mem_rd[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_rd",   32'(mem_rd[0]), 0);
        check("abort_found", 32'(found[0]), 0);
        done_cnt = 0;
        repeat (20) begin
            if (done[0]) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 0);

        // A start pulse while busy is dropped: only one done, for key 32.
        start[0] = 1'b1;
        key[0]   = 8'd32;
        @(negedge clk);
        key[0]   = 8'd0;
        check("busy_start_busy", 32'(busy[0]), 1);
        @(negedge clk);
        start[0] = 1'b0;
        check("busy_start_done_t2", 32'(done[0]), 0);
        @(negedge clk);
        check("busy_start_done_t3", 32'(done[0]), 1);
        check("busy_start_index", 32'(index[0]), 16);
        @(negedge clk);
        done_cnt = 0;
        repeat (20) begin
            if (done[0] || busy[0]) done_cnt++;
            @(negedge clk);
        end
        check("busy_start_no_second", 32'(done_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
